// File: rtl/fxdpt_div_unit_pkg.sv
// Shared types and constants for the fixed-point radix-2 divider.
package fxdpt_div_unit_pkg;

    localparam int FXDPT_W     = 32;
    localparam int DIV_LATENCY = FXDPT_W + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } fxdpt_div_state_e;

endpackage

// File: rtl/fxdpt_div_step.sv
// One combinational non-restoring division step on a W+1 bit partial remainder.
module fxdpt_div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   rem_in,
    input  logic [W-1:0] div,
    input  logic         bit_in,
    output logic [W:0]   rem_out,
    output logic         q_bit
);

    logic [W:0] shifted;

    // Wraparound of the shifted value is harmless: the true result always lies in [-div, div).
    always_comb begin
        shifted = {rem_in[W-1:0], bit_in};
        if (rem_in[W])
            rem_out = shifted + {1'b0, div};
        else
            rem_out = shifted - {1'b0, div};
        q_bit = ~rem_out[W];
    end

endmodule

// File: rtl/fxdpt_div_unit.sv
// Multi-cycle radix-2 non-restoring divider (divw/divwu) with remainder and overflow flag.
// Optional FXDPT_DIV_EARLY_OUT_EN: special cases, b==1 and a==0 complete in one cycle.
module fxdpt_div_unit
    import fxdpt_div_unit_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         is_signed,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         flush,
    output logic         ready,
    output logic         busy,
    output logic         valid,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem,
    output logic         ov
);

    localparam int CNT_W = $clog2(W);

    fxdpt_div_state_e state;
    logic [CNT_W-1:0] cnt;
    logic [W:0]       pr, pr_nxt;
    logic [W-1:0]     dvd, dvs;
    logic             neg_q, neg_r, special;
    logic             q_bit;

    logic             a_neg, b_neg, is_special, accept;
    logic [W-1:0]     abs_a, abs_b, r_fix;

    assign ready  = (state == IDLE) || (state == DONE);
    assign busy   = (state == CALC) || (state == FIX);
    assign accept = start && ready && !flush;

    assign a_neg      = is_signed && a[W-1];
    assign b_neg      = is_signed && b[W-1];
    assign abs_a      = a_neg ? -a : a;
    assign abs_b      = b_neg ? -b : b;
    assign is_special = (b == '0) || (is_signed && (a == {1'b1, {(W-1){1'b0}}}) && (b == '1));

    // Final positive remainder is below the divisor, so W bits suffice.
    assign r_fix = pr[W] ? (pr[W-1:0] + dvs) : pr[W-1:0];

`ifdef FXDPT_DIV_EARLY_OUT_EN
    logic         early_out;
    logic [W-1:0] early_q;
    assign early_out = is_special || (b == W'(1)) || (a == '0);
    assign early_q   = (!is_special && (b == W'(1))) ? a : '0;
`endif

    fxdpt_div_step #(.W(W)) u_step (
        .rem_in  (pr),
        .div     (dvs),
        .bit_in  (dvd[W-1]),
        .rem_out (pr_nxt),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            valid   <= 1'b0;
            quot    <= '0;
            rem     <= '0;
            ov      <= 1'b0;
            cnt     <= '0;
            pr      <= '0;
            dvd     <= '0;
            dvs     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            special <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        pr      <= '0;
                        dvd     <= abs_a;
                        dvs     <= abs_b;
                        cnt     <= CNT_W'(W - 1);
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        special <= is_special;
`ifdef FXDPT_DIV_EARLY_OUT_EN
                        if (early_out) begin
                            state <= DONE;
                            valid <= 1'b1;
                            quot  <= early_q;
                            rem   <= '0;
                            ov    <= is_special;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        pr  <= pr_nxt;
                        dvd <= {dvd[W-2:0], q_bit};
                        cnt <= cnt - 1'b1;
                        if (cnt == '0)
                            state <= FIX;
                    end
                end
                FIX: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        // dvd now holds the unsigned quotient magnitude
                        quot  <= special ? '0 : (neg_q ? -dvd : dvd);
                        rem   <= special ? '0 : (neg_r ? -r_fix : r_fix);
                        ov    <= special;
                        valid <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fxdpt_div_unit.sv
// Randomised self-checking bench for fxdpt_div_unit against an arithmetic reference model.
module tb_fxdpt_div_unit;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic         clk = 1'b0;
    logic         reset, start, is_signed, flush;
    logic [W-1:0] a, b;
    logic         ready, busy, valid, ov;
    logic [W-1:0] quot, rem;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] last_q, last_r;
    logic         last_ov;

    always #5 clk = ~clk;

    fxdpt_div_unit #(.W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .ready     (ready),
        .busy      (busy),
        .valid     (valid),
        .quot      (quot),
        .rem       (rem),
        .ov        (ov)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input bit sgn, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic o, output int lat);
        bit sp;
        int sx, sy;
        sp = (y == 0) || (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
        if (sp) begin
            q = '0; r = '0; o = 1'b1;
        end else if (sgn) begin
            sx = x; sy = y;
            q = sx / sy; r = sx % sy; o = 1'b0;
        end else begin
            q = x / y; r = x % y; o = 1'b0;
        end
        lat = LAT;
`ifdef FXDPT_DIV_EARLY_OUT_EN
        if (sp || y == 1 || x == 0) lat = 1;
`endif
    endfunction

    // Called at a negedge; leaves us at the negedge of the cycle after acceptance.
    task automatic issue(input bit sgn, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1; is_signed = sgn; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge of the cycle in which valid is seen (or after the budget).
    task automatic wait_result(input string tag, input bit sgn, input logic [W-1:0] x,
                               input logic [W-1:0] y);
        logic [W-1:0] eq, er;
        logic         eo;
        int           elat, k;
        bit           ready_seen;
        model(sgn, x, y, eq, er, eo, elat);
        k = 1;
        ready_seen = 1'b0;
        while (valid !== 1'b1 && k <= LAT + 20) begin
            if (ready === 1'b1) ready_seen = 1'b1;
            @(negedge clk);
            k++;
        end
        chk({tag, "_lat"}, 32'(k), 32'(elat));
        chk({tag, "_rdy_busy"}, 32'(ready_seen), 32'(0));
        chk({tag, "_quot"}, quot, eq);
        chk({tag, "_rem"}, rem, er);
        chk({tag, "_ov"}, 32'(ov), 32'(eo));
        last_q = eq; last_r = er; last_ov = eo;
    endtask

    task automatic run_op(input string tag, input bit sgn, input logic [W-1:0] x,
                          input logic [W-1:0] y);
        @(negedge clk);
        issue(sgn, x, y);
        wait_result(tag, sgn, x, y);
    endtask

    task automatic expect_no_valid(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (valid === 1'b1) seen++;
            @(negedge clk);
        end
        chk(tag, 32'(seen), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        bit           rs;
        reset = 1'b1; start = 1'b0; is_signed = 1'b0; flush = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(valid), 32'(0));
        chk("rst_quot", quot, 32'(0));
        chk("rst_rem", rem, 32'(0));
        chk("rst_ov", 32'(ov), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'(1));

        run_op("u100_7", 1'b0, 32'd100, 32'd7);
        @(negedge clk);
        chk("valid_pulse", 32'(valid), 32'(0));
        run_op("s_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7);
        run_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("u_5_0", 1'b0, 32'd5, 32'd0);
        run_op("u_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("s_min_1", 1'b1, 32'h8000_0000, 32'd1);

        // Back-to-back: new start in the DONE cycle of the previous op.
        run_op("b2b_first", 1'b0, 32'd1000, 32'd7);
        chk("b2b_prev_quot", quot, 32'd142);
        issue(1'b0, 32'd50, 32'd5);
        wait_result("b2b_second", 1'b0, 32'd50, 32'd5);

        // Flush at T+10 discards the operation.
        @(negedge clk);
        issue(1'b0, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_ready", 32'(ready), 32'(1));
        chk("flush_busy", 32'(busy), 32'(0));
        chk("flush_quot", quot, last_q);
        chk("flush_rem", rem, last_r);
        expect_no_valid("flush_no_valid", LAT + 10);

        // Flush together with start in IDLE drops the start.
        start = 1'b1; is_signed = 1'b0; a = 32'd77; b = 32'd3; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", 32'(busy), 32'(0));
        expect_no_valid("flush_start_no_valid", LAT + 10);
        chk("flush_start_quot", quot, last_q);

        // Reset at T+20 mid-operation.
        issue(1'b1, 32'd12345, 32'd11);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_valid", 32'(valid), 32'(0));
        chk("midrst_quot", quot, 32'(0));
        chk("midrst_rem", rem, 32'(0));
        chk("midrst_ov", 32'(ov), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_ready", 32'(ready), 32'(1));
        expect_no_valid("midrst_no_valid", LAT + 10);

        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: ra = '0;
                1: ra = 32'h8000_0000;
                2: ra = 32'hFFFF_FFFF;
                3: ra = $urandom_range(0, 200);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = 32'd1;
                2: rb = 32'hFFFF_FFFF;
                3: rb = $urandom_range(1, 20);
                default: rb = $urandom;
            endcase
            run_op("rand", rs, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
